// File: rtl/read_pointer.sv
// Read-side pointer and status controller for a dual-clock asynchronous FIFO.
// Everything here lives in the rclk domain. The write pointer arrives already
// synchronized (Gray-coded). This block advances the binary read counter,
// publishes a registered Gray read pointer, and derives registered
// empty / almost-empty / occupancy / read-valid / sticky-underflow status.
module read_pointer #(
    parameter int ADDR_SIZE     = 4,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                 rclk,
    input  logic                 r_rst_n,
    input  logic                 r_en,
    input  logic [ADDR_SIZE:0]   w_ptr_sync,
    input  logic                 uf_clr,
    output logic [ADDR_SIZE-1:0] r_addr,
    output logic [ADDR_SIZE:0]   r_ptr,
    output logic                 empty,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   r_count,
    output logic                 rd_valid,
    output logic                 underflow
);

    // Threshold resized to pointer width so the compare is width-matched.
    localparam logic [ADDR_SIZE:0] AE_LIMIT = (ADDR_SIZE + 1)'(AEMPTY_THRESH);

    logic [ADDR_SIZE:0] bin_reg;
    logic [ADDR_SIZE:0] bin_next;
    logic [ADDR_SIZE:0] gray_next;
    logic [ADDR_SIZE:0] wbin;
    logic [ADDR_SIZE:0] cnt_next;
    logic               accept;
    logic               underflow_next;

    // A read is only taken when the registered empty flag says data is there;
    // because empty updates on the same edge as the last accept, back-to-back
    // reads can never run past the write pointer.
    assign accept    = r_en & ~empty;
    assign bin_next  = bin_reg + {{ADDR_SIZE{1'b0}}, accept};
    assign gray_next = bin_next ^ (bin_next >> 1);
    assign r_addr    = bin_reg[ADDR_SIZE-1:0];

    // Gray-to-binary of the synchronized write pointer: each binary bit is the
    // XOR of all Gray bits from the MSB down to that position.
    genvar gi;
    generate
        for (gi = 0; gi <= ADDR_SIZE; gi++) begin : g_gray2bin
            assign wbin[gi] = ^w_ptr_sync[ADDR_SIZE:gi];
        end
    endgenerate

    // Modular subtraction keeps the occupancy right across pointer wrap.
    assign cnt_next = wbin - bin_next;

    // Sticky underflow: a read attempted while empty sets it; a clear in the
    // same cycle loses to the set.
    always_comb begin
        underflow_next = underflow;
        if (r_en && empty) begin
            underflow_next = 1'b1;
        end else if (uf_clr) begin
            underflow_next = 1'b0;
        end
    end

    // Pointer and status registers; reset is asynchronous so the FIFO reads as
    // empty immediately when reset is asserted, without waiting for a clock.
    always_ff @(posedge rclk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            bin_reg      <= '0;
            r_ptr        <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            r_count      <= '0;
            rd_valid     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            bin_reg      <= bin_next;
            r_ptr        <= gray_next;
            // Plain full-width Gray equality: equal pointers mean nothing to read.
            empty        <= (gray_next == w_ptr_sync);
            almost_empty <= (cnt_next <= AE_LIMIT);
            r_count      <= cnt_next;
            rd_valid     <= accept;
            underflow    <= underflow_next;
        end
    end

endmodule

// File: tb/tb_read_pointer.sv
// Self-checking bench for read_pointer (ADDR_SIZE=4, AEMPTY_THRESH=2).
// A behavioural model tracks total reads and the write count as integers and
// derives every status output from modular occupancy; a negedge process
// compares the DUT against it every cycle. Directed scenarios add literal
// expectations, then a randomized phase exercises mixed traffic.
module tb_read_pointer;

    localparam int AS  = 4;
    localparam int AE  = 2;
    localparam int MOD = 32;
    localparam int DEP = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        r_en = 1'b0;
    logic        uf_clr = 1'b0;
    logic [4:0]  w_ptr_sync = 5'd0;
    logic [3:0]  r_addr;
    logic [4:0]  r_ptr;
    logic        empty;
    logic        almost_empty;
    logic [4:0]  r_count;
    logic        rd_valid;
    logic        underflow;

    int checks = 0;
    int errors = 0;
    int t_wbin = 0;

    // Model state: number of reads taken (mod 32) and derived status.
    int m_rd = 0;
    int m_count = 0;
    bit m_empty = 1'b1;
    bit m_ae = 1'b1;
    bit m_rdv = 1'b0;
    bit m_uf = 1'b0;

    read_pointer #(.ADDR_SIZE(AS), .AEMPTY_THRESH(AE)) dut (
        .rclk         (clk),
        .r_rst_n      (rst_n),
        .r_en         (r_en),
        .w_ptr_sync   (w_ptr_sync),
        .uf_clr       (uf_clr),
        .r_addr       (r_addr),
        .r_ptr        (r_ptr),
        .empty        (empty),
        .almost_empty (almost_empty),
        .r_count      (r_count),
        .rd_valid     (rd_valid),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    function automatic int gray(input int v);
        int b;
        b = v % MOD;
        return b ^ (b >> 1);
    endfunction

    function automatic int occ(input int w, input int r);
        return (((w - r) % MOD) + MOD) % MOD;
    endfunction

    function automatic int take(input bit en, input bit emp);
        return (en && !emp) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_w(input int v);
        t_wbin     = v % MOD;
        w_ptr_sync = 5'(gray(t_wbin));
    endtask

    // Drive inputs for one cycle, then return just after the sampling edge.
    task automatic cyc(input bit en, input bit clr);
        r_en   = en;
        uf_clr = clr;
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: occupancy is write count minus read count, modulo 32.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rd    <= 0;
            m_count <= 0;
            m_empty <= 1'b1;
            m_ae    <= 1'b1;
            m_rdv   <= 1'b0;
            m_uf    <= 1'b0;
        end else begin
            m_rdv   <= (take(r_en, m_empty) == 1);
            m_uf    <= (r_en && m_empty) ? 1'b1 : (uf_clr ? 1'b0 : m_uf);
            m_rd    <= (m_rd + take(r_en, m_empty)) % MOD;
            m_count <= occ(t_wbin, m_rd + take(r_en, m_empty));
            m_empty <= (occ(t_wbin, m_rd + take(r_en, m_empty)) == 0);
            m_ae    <= (occ(t_wbin, m_rd + take(r_en, m_empty)) <= AE);
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        chk("cmp_r_addr",       int'(r_addr),       m_rd % DEP);
        chk("cmp_r_ptr",        int'(r_ptr),        gray(m_rd));
        chk("cmp_empty",        int'(empty),        int'(m_empty));
        chk("cmp_almost_empty", int'(almost_empty), int'(m_ae));
        chk("cmp_r_count",      int'(r_count),      m_count);
        chk("cmp_rd_valid",     int'(rd_valid),     int'(m_rdv));
        chk("cmp_underflow",    int'(underflow),    int'(m_uf));
    end

    initial begin
        int o;
        int add;

        // Reset held: reads must be ignored, outputs at reset values.
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc((i % 2) == 1, 1'b0);
            chk("rst_empty",    int'(empty), 1);
            chk("rst_ae",       int'(almost_empty), 1);
            chk("rst_count",    int'(r_count), 0);
            chk("rst_ptr",      int'(r_ptr), 0);
            chk("rst_addr",     int'(r_addr), 0);
            chk("rst_rdv",      int'(rd_valid), 0);
            chk("rst_uf",       int'(underflow), 0);
        end
        r_en  = 1'b0;
        rst_n = 1'b1;
        cyc(1'b0, 1'b0);

        // Fill with three entries and drain them.
        set_w(3);
        cyc(1'b0, 1'b0);
        chk("fill_count", int'(r_count), 3);
        chk("fill_empty", int'(empty), 0);
        chk("fill_ae",    int'(almost_empty), 0);
        for (int i = 0; i < 3; i++) begin
            chk("drain_addr", int'(r_addr), i);
            cyc(1'b1, 1'b0);
            chk("drain_rdv",   int'(rd_valid), 1);
            chk("drain_count", int'(r_count), 2 - i);
            chk("drain_ae",    int'(almost_empty), 1);
            chk("drain_empty", int'(empty), (i == 2) ? 1 : 0);
        end
        chk("drain_ptr", int'(r_ptr), 2);
        cyc(1'b0, 1'b0);
        chk("drain_rdv_end", int'(rd_valid), 0);

        // Underflow: set, hold, clear, and set-beats-clear.
        cyc(1'b1, 1'b0);
        chk("uf_set",   int'(underflow), 1);
        chk("uf_rdv",   int'(rd_valid), 0);
        chk("uf_addr",  int'(r_addr), 3);
        cyc(1'b0, 1'b0);
        chk("uf_hold",  int'(underflow), 1);
        cyc(1'b0, 1'b1);
        chk("uf_clr",   int'(underflow), 0);
        cyc(1'b1, 1'b1);
        chk("uf_win",   int'(underflow), 1);
        cyc(1'b0, 1'b1);
        chk("uf_clr2",  int'(underflow), 0);

        // Advance to r_addr 7 with data left, then assert reset between edges.
        set_w(9);
        cyc(1'b0, 1'b0);
        repeat (4) cyc(1'b1, 1'b0);
        chk("pre_arst_addr", int'(r_addr), 7);
        r_en = 1'b0;
        #2;
        rst_n = 1'b0;
        set_w(0);
        #1;
        chk("arst_addr",  int'(r_addr), 0);
        chk("arst_empty", int'(empty), 1);
        chk("arst_ptr",   int'(r_ptr), 0);
        chk("arst_count", int'(r_count), 0);
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b0);
        rst_n = 1'b1;
        cyc(1'b0, 1'b0);

        // Full occupancy: 16 entries, then read them all.
        set_w(16);
        cyc(1'b0, 1'b0);
        chk("full_count", int'(r_count), 16);
        chk("full_empty", int'(empty), 0);
        chk("full_ae",    int'(almost_empty), 0);
        repeat (16) cyc(1'b1, 1'b0);
        chk("full_drained_empty", int'(empty), 1);
        chk("full_drained_ptr",   int'(r_ptr), 24);
        chk("full_drained_count", int'(r_count), 0);

        // Wrap: bring the read counter to 30, then read across 31 -> 0.
        set_w(30);
        cyc(1'b0, 1'b0);
        repeat (14) cyc(1'b1, 1'b0);
        chk("wrap_start_addr", int'(r_addr), 14);
        set_w(34);
        cyc(1'b0, 1'b0);
        chk("wrap_count", int'(r_count), 4);
        for (int i = 0; i < 4; i++) begin
            chk("wrap_addr", int'(r_addr), (14 + i) % 16);
            cyc(1'b1, 1'b0);
            chk("wrap_step_count", int'(r_count), 3 - i);
        end
        chk("wrap_end_addr",  int'(r_addr), 2);
        chk("wrap_end_empty", int'(empty), 1);
        chk("wrap_end_ptr",   int'(r_ptr), 3);

        // Write arrives in the same cycle as the read of the only entry.
        set_w(3);
        cyc(1'b0, 1'b0);
        chk("sim_pre_count", int'(r_count), 1);
        set_w(4);
        cyc(1'b1, 1'b0);
        chk("sim_count", int'(r_count), 1);
        chk("sim_empty", int'(empty), 0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);

        // Randomized traffic; write side never exceeds 16 outstanding entries.
        repeat (3000) begin
            o   = occ(t_wbin, m_rd);
            add = int'($urandom_range(0, 2));
            if (o + add > DEP) add = DEP - o;
            set_w(t_wbin + add);
            cyc($urandom_range(0, 99) < 65, $urandom_range(0, 99) < 8);
        end
        r_en   = 1'b0;
        uf_clr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/read_pointer.md
# read_pointer

Read-side pointer and status controller for the dual-clock asynchronous FIFO, mirroring the write-side pointer logic. Runs entirely in the read clock domain:
- advances the binary read address on accepted reads;
- publishes a registered Gray read pointer for synchronization into the write domain;
- produces registered empty, almost-empty, occupancy count, read-data-valid and sticky underflow status from the write pointer already synchronized into `rclk`.

## Interface
- `ADDR_SIZE`, 4: memory address width; FIFO depth is 2^ADDR_SIZE; pointers are ADDR_SIZE+1 bits.
- `AEMPTY_THRESH`, 2: almost_empty asserts when occupancy <= this value; legal range 0..2^ADDR_SIZE.

- `rclk`  in  1  read clock; one clock; all state on rising edge.
- `r_rst_n`  in  1  reset, asynchronous and active-low.
- `r_en`  in  1  read request.
- `w_ptr_sync`  in  ADDR_SIZE+1  Gray write pointer, already 2-flop synchronized into rclk (synchronizer is external).
- `uf_clr`  in  1  clears sticky underflow.
- `r_addr`  out  ADDR_SIZE  memory read address = low bits of binary read counter.
- `r_ptr`  out  ADDR_SIZE+1  registered Gray read pointer, to write-domain synchronizer.
- `empty`  out  1  registered empty flag.
- `almost_empty`  out  1  registered; occupancy <= AEMPTY_THRESH.
- `r_count`  out  ADDR_SIZE+1  registered occupancy as seen from read domain, 0..2^ADDR_SIZE.
- `rd_valid`  out  1  high one cycle after an accepted read.
- `underflow`  out  1  sticky: read attempted while empty.

## Operation
- Accept = `r_en & ~empty`. Binary counter `bin` (ADDR_SIZE+1 bits) next value `bin_next = bin + accept`, wrapping modulo 2^(ADDR_SIZE+1).
- `gray_next = bin_next ^ (bin_next >> 1)`; on every edge `bin <= bin_next`, `r_ptr <= gray_next`.
- `r_addr = bin[ADDR_SIZE-1:0]`, combinational from the register.
- Empty: `empty <= (gray_next == w_ptr_sync)`, full-width Gray compare; no MSB inversion, unlike full.
- Occupancy:
  - Convert `w_ptr_sync` Gray to binary `wbin` (XOR-prefix from MSB).
  - `cnt_next = wbin - bin_next`, modulo 2^(ADDR_SIZE+1).
  - `r_count <= cnt_next`; `almost_empty <= (cnt_next <= AEMPTY_THRESH)`.
- `rd_valid <= accept`.
- Underflow:
  - `r_en & empty` sets `underflow` on the next edge; `bin` is unchanged and `rd_valid` stays 0.
  - `uf_clr` clears `underflow`; a set in the same cycle wins.
- `empty`, `r_count` and `almost_empty` are pessimistic: they lag true writes by the external synchronizer latency and never report data that has not yet crossed.

## Timing
- Reset values:
  - `bin=0`, `r_addr=0`, `r_ptr=0`.
  - `empty=1`, `almost_empty=1`, `r_count=0`.
  - `rd_valid=0`, `underflow=0`.
- Reset is asynchronous. Asserting reset mid-operation forces all of the above immediately. Deassertion is synchronous to `rclk`; the first edge after release behaves as normal operation.
- Read accepted in cycle N:
  - `r_addr` and `r_ptr` advance at edge N+1.
  - `rd_valid` is high in cycle N+1, aligned with a synchronous-read memory addressed by `r_addr` in cycle N.
- `empty` asserts at the same edge as the accept of the last entry, so back-to-back reads never over-read.
- A `w_ptr_sync` change in cycle k is reflected in `empty`, `r_count` and `almost_empty` at edge k+1. A read accept in the same cycle is included in the same update.
- Wrap: `bin` going 2^(ADDR_SIZE+1)-1 -> 0 is a normal increment; `r_count` stays correct through wrap by modular subtraction.
- Throughput: one read per cycle sustained while not empty.

## Test plan
All scenarios use ADDR_SIZE=4 and AEMPTY_THRESH=2.
- **Reset:** hold `r_rst_n=0`, toggle `r_en` -> all outputs at reset values. Assert reset asynchronously mid-stream with `bin=7` -> `r_addr=0`, `empty=1` immediately, no clock required.
- **Fill and drain:** drive `w_ptr_sync=5'b00010` (binary 3) -> next edge `empty=0`, `r_count=3`, `almost_empty=0`. Hold `r_en` 3 cycles:
  - `r_addr` sequence 0,1,2;
  - `rd_valid` high 3 cycles, each one cycle late;
  - `r_count` goes 2 then 1 then 0;
  - `almost_empty=1` once count=2;
  - `empty=1` at the third accept edge;
  - final `r_ptr=5'b00010`.
- **Underflow:** `r_en=1` while empty -> `bin` unchanged, `rd_valid=0`, `underflow=1` next edge and held. Pulse `uf_clr` -> cleared. `uf_clr` together with empty read -> `underflow` stays 1.
- **Full occupancy:** `w_ptr_sync=5'b11000` (binary 16), `bin=0` -> `r_count=16`, `empty=0`. Read 16 -> `empty=1`, `r_ptr=5'b11000`.
- **Wrap:** start from `bin=30`, `w_ptr_sync` = Gray(2) (count 4) -> four reads give `r_addr` 14,15,0,1, `bin` ends at 2, `empty=1`. `r_count` is correct at every step.
- **Simultaneous:** `w_ptr_sync` increments in the same cycle as an accepted read with count=1 -> next edge `r_count=1`, `empty=0`.
